// File: rtl/mac_fp_dot5_seq.sv
// mac_fp_dot5_seq: sequencer closing the accumulation loop around a
// combinational 5-way-select FP MAC to produce a TERMS-long dot product.
module mac_fp_dot5_seq #(
  parameter int inst_sig_width = 23,
  parameter int inst_exp_width = 8,
  parameter int TERMS          = 5
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic                                                abort,
  input  logic [(inst_sig_width+inst_exp_width+1)*TERMS-1:0]  b_vec,
  input  logic [inst_sig_width+inst_exp_width:0]              c_init,
  input  logic [2:0]                                          rnd,
  output logic                                                busy,
  output logic                                                done,
  output logic [inst_sig_width+inst_exp_width:0]              result,
  output logic [7:0]                                          status_or,
  output logic [2:0]                                          mac_select,
  output logic [inst_sig_width+inst_exp_width:0]              mac_b,
  output logic [inst_sig_width+inst_exp_width:0]              mac_c,
  output logic [2:0]                                          mac_rnd,
  input  logic [inst_sig_width+inst_exp_width:0]              mac_z,
  input  logic [7:0]                                          mac_status
);

  localparam int W = inst_sig_width + inst_exp_width + 1;
  localparam logic [2:0] LAST = 3'(TERMS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [2:0]         idx;
  logic [W-1:0]       acc;
  logic [W*TERMS-1:0] b_lat;
  logic [2:0]         rnd_lat;
  logic [7:1]         stat;
  logic [7:0]         stat_nx;
  logic [W-1:0]       b_sel;
  logic               accept;
  logic               last;

  assign accept  = start && (state == IDLE || state == DONE);
  assign last    = (idx == LAST);
  assign stat_nx = {stat | mac_status[7:1], mac_status[0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; abort only matters while running
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pick the latched b operand for the current term
  always_comb begin
    b_sel = '0;
    for (int i = 0; i < TERMS; i++) begin
      if (idx == 3'(i)) b_sel = b_lat[W*i +: W];
    end
  end

  // Requester handshake and MAC drive; MAC inputs are parked at zero
  // outside RUN so the datapath is quiet between operations
  always_comb begin
    busy       = (state == RUN);
    done       = (state == DONE);
    mac_select = 3'd0;
    mac_b      = '0;
    mac_c      = '0;
    mac_rnd    = rnd_lat;
    if (state == RUN) begin
      mac_select = idx;
      mac_b      = b_sel;
      mac_c      = acc;
    end
  end

  // Operand latch, accumulation loop and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 3'd0;
      acc       <= '0;
      b_lat     <= '0;
      rnd_lat   <= 3'd0;
      stat      <= '0;
      result    <= '0;
      status_or <= 8'd0;
    end else if (accept) begin
      idx     <= 3'd0;
      acc     <= c_init;
      b_lat   <= b_vec;
      rnd_lat <= rnd;
      stat    <= '0;
    end else if (state == RUN) begin
      if (abort) begin
        idx <= 3'd0;
      end else begin
        acc  <= mac_z;
        stat <= stat_nx[7:1];
        idx  <= last ? 3'd0 : idx + 3'd1;
        if (last) begin
          result    <= mac_z;
          status_or <= stat_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_fp_dot5_seq.sv
// tb_mac_fp_dot5_seq: directed bench with a behavioural FP32 MAC model
// and a done-driven scoreboard monitor.
module tb_mac_fp_dot5_seq;

  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] TWO   = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000;
  localparam logic [31:0] FOUR  = 32'h40800000;
  localparam logic [31:0] FIVE  = 32'h40A00000;
  localparam logic [31:0] TEN   = 32'h41200000;
  localparam logic [31:0] INF   = 32'h7F800000;
  localparam logic [31:0] QNAN  = 32'h7FC00000;
  localparam logic [31:0] ZERO  = 32'h00000000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [159:0] b_vec;
  logic [31:0]  c_init;
  logic [2:0]   rnd;
  logic         busy;
  logic         done;
  logic [31:0]  result;
  logic [7:0]   status_or;
  logic [2:0]   mac_select;
  logic [31:0]  mac_b;
  logic [31:0]  mac_c;
  logic [2:0]   mac_rnd;
  logic [31:0]  mac_z;
  logic [7:0]   mac_status;
  logic [159:0] a_vec;

  typedef struct {
    logic [31:0] r;
    logic [7:0]  s;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  mac_fp_dot5_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .b_vec      (b_vec),
    .c_init     (c_init),
    .rnd        (rnd),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .status_or  (status_or),
    .mac_select (mac_select),
    .mac_b      (mac_b),
    .mac_c      (mac_c),
    .mac_rnd    (mac_rnd),
    .mac_z      (mac_z),
    .mac_status (mac_status)
  );

  always #5 clk = ~clk;

  function automatic real to_real(input logic [31:0] x);
    real m;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    m = m * (2.0 ** real'(int'(x[30:23]) - 127));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] from_real(input real v);
    logic s;
    int   e;
    real  r;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    r = s ? -v : v;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, 8'(e), 23'($rtoi((r - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [39:0] mac(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] c);
    logic an, bn, cn, ai, bi, ci, az, bz, ps;
    logic [31:0] z;
    logic [7:0]  st;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    cn = (c[30:23] == 8'hFF) && (c[22:0] != 0);
    ai = (a[30:0] == INF[30:0]);
    bi = (b[30:0] == INF[30:0]);
    ci = (c[30:0] == INF[30:0]);
    az = (a[30:0] == 31'd0);
    bz = (b[30:0] == 31'd0);
    ps = a[31] ^ b[31];
    st = 8'd0;
    if (an || bn || cn) begin
      z = QNAN;
    end else if (ai || bi) begin
      if (az || bz || (ci && c[31] != ps)) begin
        z = QNAN;
        st[2] = 1'b1;
      end else begin
        z = {ps, INF[30:0]};
        st[1] = 1'b1;
      end
    end else if (ci) begin
      z = c;
      st[1] = 1'b1;
    end else begin
      z = from_real(to_real(a) * to_real(b) + to_real(c));
      st[0] = (z[30:0] == 31'd0);
      st[1] = (z[30:0] == INF[30:0]);
    end
    return {st, z};
  endfunction

  // Behavioural combinational MAC unit
  always_comb begin
    {mac_status, mac_z} = mac(a_vec[int'(mac_select)*32 +: 32], mac_b, mac_c);
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic expect_res(input logic [31:0] r, input logic [7:0] s);
    exp_t e;
    e.r = r;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] c, input logic [159:0] bv,
                       input logic [159:0] av, input logic [2:0] rm);
    @(posedge clk);
    #1;
    start  = 1'b1;
    c_init = c;
    b_vec  = bv;
    a_vec  = av;
    rnd    = rm;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: result %h status %h at %0t",
                 result, status_or, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.r);
        check("status_or", 32'(status_or), 32'(e.s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [159:0] b_std;
    logic [159:0] a_one;
    b_std  = {FIVE, FOUR, THREE, TWO, ONE};
    a_one  = {ONE, ONE, ONE, ONE, ONE};
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    b_vec  = '0;
    c_init = '0;
    rnd    = 3'd0;
    a_vec  = a_one;
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", result, 0);
    check("rst_sel", 32'(mac_select), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: basic dot product, cycle-accurate select stepping
    expect_res(32'h41700000, 8'h00);
    issue(ZERO, b_std, a_one, 3'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t1_busy", 32'(busy), 1);
      check("t1_sel", 32'(mac_select), 32'(k));
    end
    @(negedge clk);
    check("t1_done", 32'(done), 1);
    check("t1_busy_off", 32'(busy), 0);
    repeat (2) @(posedge clk);

    // 2: back-to-back, start held through the DONE cycle
    expect_res(32'h41700000, 8'h00);
    expect_res(32'h41C80000, 8'h00);
    @(posedge clk);
    #1;
    start  = 1'b1;
    c_init = ZERO;
    b_vec  = b_std;
    @(posedge clk);
    #1;
    c_init = TEN;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("t2_done", 32'(done), 32'(k == 6 || k == 12));
      check("t2_busy", 32'(busy), 32'(!(k == 6 || k == 12)));
      if (k == 6) begin
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    repeat (2) @(posedge clk);

    // 3: abort in RUN cycle 3, then a fresh request
    issue(ZERO, b_std, a_one, 3'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("t3_busy", 32'(busy), 0);
    check("t3_result_kept", result, 32'h41C80000);
    repeat (8) @(posedge clk);
    expect_res(32'h41880000, 8'h00);
    issue(TWO, b_std, a_one, 3'd0);
    repeat (8) @(posedge clk);

    // 4: asynchronous reset in RUN cycle 2
    issue(ZERO, b_std, a_one, 3'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t4_busy", 32'(busy), 0);
    check("t4_result", result, 0);
    check("t4_status", 32'(status_or), 0);
    check("t4_mac_b", mac_b, 0);
    check("t4_mac_c", mac_c, 0);
    check("t4_mac_rnd", 32'(mac_rnd), 0);
    @(negedge clk);
    rst = 1'b0;
    expect_res(32'h41700000, 8'h00);
    issue(ZERO, b_std, a_one, 3'd0);
    repeat (8) @(posedge clk);

    // 5: status accumulation (infinity, then invalid)
    expect_res(INF, 8'h02);
    issue(ZERO, b_std, {ONE, ONE, ONE, ONE, INF}, 3'd0);
    repeat (8) @(posedge clk);
    expect_res(QNAN, 8'h04);
    issue(ZERO, {FIVE, FOUR, ZERO, TWO, ONE}, {ONE, ONE, INF, ONE, ONE},
          3'd0);
    repeat (8) @(posedge clk);

    // 6: start while busy is ignored
    expect_res(32'h41700000, 8'h00);
    issue(ZERO, b_std, a_one, 3'd0);
    start  = 1'b1;
    c_init = TEN;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);

    // 7: zero flag comes from the final term only
    expect_res(ONE, 8'h00);
    issue(ZERO, {ONE, ZERO, ZERO, ZERO, ZERO}, a_one, 3'd0);
    repeat (8) @(posedge clk);
    expect_res(ZERO, 8'h01);
    issue(ZERO, '0, a_one, 3'd0);
    repeat (8) @(posedge clk);

    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
